// File: rtl/stopwatch_display_mux.sv
// Multiplexed 4-digit 7-segment driver for the stopwatch digit bus (M.SS.T), with per-frame latching and a wrap flash.
// Build option: define BLANK_ZERO_EN to blank a leading zero in the minute slot.
module stopwatch_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] minute,
  input  logic [3:0] tenSecond,
  input  logic [3:0] oneSecond,
  input  logic [3:0] tenthSecond,
  input  logic       cascade,
  input  logic       enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FL_LOAD = FW'(FLASH_FRAMES);

  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_idx;
  logic [3:0][3:0]   r_sh;
  logic [FW-1:0]     r_flash;
  logic              r_fblank;

  logic              w_tick, w_frame, w_fblank_nxt, w_zblank;
  logic [1:0]        w_idx_nxt;
  logic [3:0][3:0]   w_sh_nxt;
  logic [FW-1:0]     w_flash_nxt;
  logic [6:0]        w_seg;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b0111111;
    endcase
  endfunction

  assign w_tick    = enable && (r_cnt == CNT_MAX);
  assign w_idx_nxt = r_idx + 2'd1;
  assign w_frame   = w_tick && (r_idx == 2'd3);
  assign w_sh_nxt  = w_frame ? {minute, tenSecond, oneSecond, tenthSecond} : r_sh;

  // Load after decrement so a cascade coinciding with a frame start wins.
  always_comb begin
    w_flash_nxt = r_flash;
    if (w_frame && (r_flash != '0)) w_flash_nxt = r_flash - 1'b1;
    if (cascade) w_flash_nxt = FL_LOAD;
  end

  // Blank decision is frozen for the whole frame at its start.
  assign w_fblank_nxt = w_frame ? w_flash_nxt[0] : r_fblank;
  assign w_seg        = seg_enc(w_sh_nxt[w_idx_nxt]);

`ifdef BLANK_ZERO_EN
  assign w_zblank = (w_idx_nxt == 2'd3) && (w_sh_nxt[3] == 4'd0);
`else
  assign w_zblank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_idx    <= 2'd3;
      r_sh     <= '0;
      r_flash  <= '0;
      r_fblank <= 1'b0;
    end else begin
      if (enable) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= w_idx_nxt;
      r_sh     <= w_sh_nxt;
      r_flash  <= w_flash_nxt;
      r_fblank <= w_fblank_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (!enable || (w_tick && (w_fblank_nxt || w_zblank))) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (w_tick) begin
      an  <= ~(4'b0001 << w_idx_nxt);
      seg <= w_seg;
      dp  <= ~w_idx_nxt[0];
    end
  end

endmodule
